// File: rtl/keypad_matrix_model.sv
// Keypad matrix emulator: plays queued key codes onto active-low rows,
// following the scanner's active-low column drive.
module keypad_matrix_model #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int KEY_W         = 5,
    parameter int DEPTH         = 16,
    parameter int RELEASE_SCANS = 4,
    parameter int PRESS_SCANS   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key_valid,
    input  logic [KEY_W-1:0]             key_code,
    output logic                         key_ready,
    input  logic [COLS-1:0]              col_out,
    output logic [ROWS-1:0]              row_in,
    output logic                         busy,
    output logic                         key_done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         scan_error
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int SMAX = (RELEASE_SCANS > PRESS_SCANS) ? RELEASE_SCANS : PRESS_SCANS;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int CI_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [KEY_W:0] NKEYS = (KEY_W + 1)'(ROWS * COLS);

    typedef enum logic [1:0] {IDLE, RELEASE, PRESS} state_t;

    logic [KEY_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    state_t           state;
    logic [SW-1:0]    cnt;
    logic [KEY_W-1:0] key_reg;
    logic             prev_col0;

    logic             push;
    logic             pop;
    logic             bnd;
    logic             legal;
    logic             hit;
    logic [CI_W-1:0]  col_idx;
    logic [KEY_W-1:0] row_k;
    logic [ROWS-1:0]  press_row;

    assign key_ready = (fifo_count != CW'(DEPTH));
    assign push      = key_valid & key_ready;
    assign pop       = (state == IDLE) & (fifo_count != '0);
    assign busy      = (state != IDLE) | (fifo_count != '0);
    assign bnd       = ~col_out[0] & ~prev_col0;
    assign legal     = (&col_out) | $onehot(~col_out);

    // Illegal column patterns never reach the rows
    assign col_idx   = CI_W'(key_reg % KEY_W'(COLS));
    assign row_k     = key_reg / KEY_W'(COLS);
    assign hit       = ({1'b0, key_reg} < NKEYS) & legal & ~col_out[col_idx];
    assign press_row = hit ? ~(ROWS'(1) << row_k) : '1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop) fifo_count <= fifo_count + 1'b1;
            else if (pop & ~push) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_col0  <= 1'b0;
            scan_error <= 1'b0;
        end else begin
            prev_col0 <= ~col_out[0];
            if (!legal) scan_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            key_reg  <= '0;
            row_in   <= '1;
            key_done <= 1'b0;
        end else begin
            key_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    row_in <= '1;
                    if (pop) begin
                        key_reg <= mem[rd_ptr];
                        cnt     <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    row_in <= '1;
                    if (bnd) begin
                        if (cnt == SW'(RELEASE_SCANS - 1)) begin
                            cnt   <= '0;
                            state <= PRESS;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PRESS: begin
                    if (bnd && cnt == SW'(PRESS_SCANS - 1)) begin
                        cnt      <= '0;
                        key_done <= 1'b1;
                        row_in   <= '1;
                        state    <= IDLE;
                    end else begin
                        row_in <= press_row;
                        if (bnd) cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    row_in <= '1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_matrix_model.sv
// Bench for keypad_matrix_model: queue-based key playback model, a
// bench-driven column scanner and randomized key streams.
module tb_keypad_matrix_model;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = 5;
    localparam int DEPTH = 16;
    localparam int RS    = 4;
    localparam int PS    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_valid = 1'b0;
    logic [KEY_W-1:0] key_code = '0;
    logic             key_ready;
    logic [COLS-1:0]  col_out = '1;
    logic [ROWS-1:0]  row_in;
    logic             busy;
    logic             key_done;
    logic [4:0]       fifo_count;
    logic             scan_error;

    int checks = 0;
    int failures = 0;

    // Model: pending codes, current key phase (0 waiting, 1 release, 2 press)
    int       q[$];
    int       m_phase;
    int       m_bnds;
    int       m_key;
    bit       m_prev0;
    bit       m_err;
    bit       m_acc;
    bit       m_last_bnd;
    logic [3:0] exp_row;
    bit       exp_done;
    logic [3:0] last_col;

    bit scan_on = 1'b0;
    int sc = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    keypad_matrix_model #(
        .ROWS(ROWS), .COLS(COLS), .KEY_W(KEY_W), .DEPTH(DEPTH),
        .RELEASE_SCANS(RS), .PRESS_SCANS(PS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_ready(key_ready),
        .col_out(col_out),
        .row_in(row_in),
        .busy(busy),
        .key_done(key_done),
        .fifo_count(fifo_count),
        .scan_error(scan_error)
    );

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_bnds = 0;
        m_key = 0;
        m_prev0 = 1'b0;
        m_err = 1'b0;
        exp_row = 4'hF;
        exp_done = 1'b0;
    endtask

    task automatic model_edge();
        int zeros;
        bit bnd;
        bit legal;
        bit hit;
        zeros = 0;
        for (int i = 0; i < COLS; i++) if (!col_out[i]) zeros++;
        legal = (zeros <= 1);
        bnd = !col_out[0] && !m_prev0;
        m_last_bnd = bnd;
        last_col = col_out;
        m_acc = key_valid && (q.size() != DEPTH);
        exp_done = 1'b0;
        if (m_phase == 0) begin
            exp_row = 4'hF;
            if (q.size() > 0) begin
                m_key = q.pop_front();
                m_phase = 1;
                m_bnds = 0;
            end
        end else if (m_phase == 1) begin
            exp_row = 4'hF;
            if (bnd) begin
                m_bnds++;
                if (m_bnds == RS) begin
                    m_phase = 2;
                    m_bnds = 0;
                end
            end
        end else begin
            if (bnd && m_bnds == PS - 1) begin
                exp_done = 1'b1;
                exp_row = 4'hF;
                m_phase = 0;
                m_bnds = 0;
            end else begin
                if (bnd) m_bnds++;
                hit = (m_key < ROWS * COLS) && legal && !col_out[m_key % COLS];
                exp_row = 4'hF;
                if (hit) exp_row[m_key / COLS] = 1'b0;
            end
        end
        if (m_acc) q.push_back(int'(key_code));
        if (!legal) m_err = 1'b1;
        m_prev0 = !col_out[0];
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (scan_on) begin
            sc = (sc + 1) % 16;
            col_out = ~(4'b0001 << (sc / 4));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (row_in !== 4'hF) begin failures++; $display("FAIL reset_row_in got %b exp 1111", row_in); end
        checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL reset_key_ready got %b exp 1", key_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (key_done !== 1'b0) begin failures++; $display("FAIL reset_key_done got %b exp 0", key_done); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
        checks++; if (scan_error !== 1'b0) begin failures++; $display("FAIL reset_scan_error got %b exp 0", scan_error); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_key();
        int n_press = 0;
        bit done_seen = 1'b0;
        scan_on = 1'b1;
        key_code = 5'd6;
        key_valid = 1'b1;
        cycle();
        key_valid = 1'b0;
        for (int t = 0; t < 400 && !done_seen; t++) begin
            cycle();
            checks++; if (row_in !== exp_row) begin failures++; $display("FAIL single_row_in got %b exp %b", row_in, exp_row); end
            checks++; if (key_done !== exp_done) begin failures++; $display("FAIL single_key_done got %b exp %b", key_done, exp_done); end
            if (row_in == 4'b1101) begin
                n_press++;
                checks++; if (last_col !== 4'b1011) begin failures++; $display("FAIL single_col_follow col %b exp 1011", last_col); end
            end
            if (key_done) done_seen = 1'b1;
        end
        checks++; if (!done_seen) begin failures++; $display("FAIL single_done_timeout got 0 exp 1"); end
        checks++; if (n_press != 8) begin failures++; $display("FAIL single_press_cycles got %0d exp 8", n_press); end
        cycle();
        checks++; if (row_in !== 4'hF || key_done !== 1'b0) begin failures++; $display("FAIL single_after row %b done %b exp 1111 0", row_in, key_done); end
    endtask

    task automatic test_fifo_full();
        int codes[18];
        int n = 0;
        int dones = 0;
        bit acc = 1'b0;
        for (int i = 0; i < 18; i++) codes[i] = $urandom_range(0, 31);
        scan_on = 1'b0;
        col_out = '1;
        for (int t = 0; t < 60 && n < 17; t++) begin
            key_valid = 1'b1;
            key_code = codes[n][4:0];
            cycle();
            if (m_acc) n++;
        end
        checks++; if (n != 17) begin failures++; $display("FAIL full_accepted got %0d exp 17", n); end
        key_code = codes[17][4:0];
        repeat (3) cycle();
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL full_fifo_count got %0d exp 16", fifo_count); end
        checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL full_key_ready got %b exp 0", key_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy got %b exp 1", busy); end
        scan_on = 1'b1;
        for (int t = 0; t < 400 && !acc; t++) begin
            cycle();
            if (m_acc) acc = 1'b1;
        end
        key_valid = 1'b0;
        checks++; if (!acc) begin failures++; $display("FAIL full_pending_timeout got 0 exp 1"); end
        for (int t = 0; t < 4000 && (busy || q.size() != 0 || m_phase != 0); t++) begin
            cycle();
            checks++; if (row_in !== exp_row) begin failures++; $display("FAIL drain_row_in got %b exp %b", row_in, exp_row); end
            checks++; if (key_done !== exp_done) begin failures++; $display("FAIL drain_key_done got %b exp %b", key_done, exp_done); end
            checks++; if (fifo_count !== 5'(q.size())) begin failures++; $display("FAIL drain_fifo_count got %0d exp %0d", fifo_count, q.size()); end
            checks++; if (key_ready !== (q.size() != DEPTH)) begin failures++; $display("FAIL drain_key_ready got %b", key_ready); end
            if (key_done) dones++;
        end
        checks++; if (dones != 17) begin failures++; $display("FAIL drain_done_count got %0d exp 17", dones); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy got %b exp 0", busy); end
    endtask

    task automatic test_no_key();
        int nb = 0;
        bit done_seen = 1'b0;
        key_code = 5'd16;
        key_valid = 1'b1;
        cycle();
        key_valid = 1'b0;
        cycle();
        for (int t = 0; t < 300 && !done_seen; t++) begin
            cycle();
            if (m_last_bnd) nb++;
            checks++; if (row_in !== 4'hF) begin failures++; $display("FAIL nokey_row_in got %b exp 1111", row_in); end
            if (key_done) done_seen = 1'b1;
        end
        checks++; if (!done_seen) begin failures++; $display("FAIL nokey_done_timeout got 0 exp 1"); end
        checks++; if (nb != RS + PS) begin failures++; $display("FAIL nokey_boundaries got %0d exp %0d", nb, RS + PS); end
    endtask

    task automatic test_scan_error();
        bit done_seen = 1'b0;
        key_code = 5'd0;
        key_valid = 1'b1;
        cycle();
        key_valid = 1'b0;
        for (int t = 0; t < 300 && m_phase != 2; t++) cycle();
        repeat (3) cycle();
        checks++; if (scan_error !== 1'b0) begin failures++; $display("FAIL err_before got %b exp 0", scan_error); end
        col_out = 4'b1100;
        cycle();
        checks++; if (scan_error !== 1'b1) begin failures++; $display("FAIL err_set got %b exp 1", scan_error); end
        checks++; if (row_in !== 4'hF) begin failures++; $display("FAIL err_row_in got %b exp 1111", row_in); end
        for (int t = 0; t < 300 && !done_seen; t++) begin
            cycle();
            checks++; if (row_in !== exp_row) begin failures++; $display("FAIL err_row_follow got %b exp %b", row_in, exp_row); end
            if (key_done) done_seen = 1'b1;
        end
        checks++; if (scan_error !== 1'b1) begin failures++; $display("FAIL err_sticky got %b exp 1", scan_error); end
        checks++; if (m_err !== 1'b1) begin failures++; $display("FAIL err_model got %b exp 1", m_err); end
    endtask

    task automatic test_mid_reset();
        bit done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_code = 5'($urandom_range(0, 15));
            key_valid = 1'b1;
            cycle();
        end
        key_valid = 1'b0;
        for (int t = 0; t < 300 && m_phase != 2; t++) cycle();
        repeat (5) cycle();
        checks++; if (fifo_count !== 5'd3) begin failures++; $display("FAIL rst_queued got %0d exp 3", fifo_count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (row_in !== 4'hF) begin failures++; $display("FAIL rst_row_in got %b exp 1111", row_in); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL rst_fifo_count got %0d exp 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (scan_error !== 1'b0) begin failures++; $display("FAIL rst_scan_error got %b exp 0", scan_error); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        key_code = 5'd9;
        key_valid = 1'b1;
        cycle();
        key_valid = 1'b0;
        for (int t = 0; t < 300 && !done_seen; t++) begin
            cycle();
            checks++; if (row_in !== exp_row) begin failures++; $display("FAIL rst_resume_row got %b exp %b", row_in, exp_row); end
            checks++; if (key_done !== exp_done) begin failures++; $display("FAIL rst_resume_done got %b exp %b", key_done, exp_done); end
            if (key_done) done_seen = 1'b1;
        end
        checks++; if (!done_seen) begin failures++; $display("FAIL rst_resume_timeout got 0 exp 1"); end
    endtask

    task automatic test_back_to_back();
        int t_done[$];
        int first_a = -1;
        int first_b = -1;
        key_valid = 1'b1;
        key_code = 5'd1;
        cycle();
        key_code = 5'd15;
        cycle();
        key_valid = 1'b0;
        for (int t = 0; t < 700 && t_done.size() < 2; t++) begin
            cycle();
            checks++; if (row_in !== exp_row) begin failures++; $display("FAIL b2b_row_in got %b exp %b", row_in, exp_row); end
            if (row_in == 4'b1110 && first_a < 0) first_a = cyc;
            if (row_in == 4'b0111 && first_b < 0) first_b = cyc;
            if (row_in == 4'b1110) begin
                checks++; if (last_col !== 4'b1101) begin failures++; $display("FAIL b2b_col1 col %b exp 1101", last_col); end
            end
            if (row_in == 4'b0111) begin
                checks++; if (last_col !== 4'b0111) begin failures++; $display("FAIL b2b_col3 col %b exp 0111", last_col); end
            end
            if (key_done) t_done.push_back(cyc);
        end
        checks++; if (t_done.size() != 2) begin failures++; $display("FAIL b2b_done_count got %0d exp 2", t_done.size()); end
        if (t_done.size() == 2) begin
            checks++; if (t_done[1] - t_done[0] < 96) begin failures++; $display("FAIL b2b_gap got %0d exp >=96", t_done[1] - t_done[0]); end
        end
        checks++; if (first_a < 0 || first_b < 0 || first_a >= first_b) begin failures++; $display("FAIL b2b_order got %0d %0d exp ordered", first_a, first_b); end
    endtask

    task automatic test_random();
        int sent = 0;
        for (int t = 0; t < 5000 && (sent < 20 || busy || q.size() != 0 || m_phase != 0); t++) begin
            if (sent < 20 && $urandom_range(0, 3) == 0) begin
                key_valid = 1'b1;
                key_code = 5'($urandom_range(0, 20));
            end else begin
                key_valid = 1'b0;
            end
            cycle();
            if (m_acc) sent++;
            checks++; if (row_in !== exp_row) begin failures++; $display("FAIL rand_row_in got %b exp %b", row_in, exp_row); end
            checks++; if (key_done !== exp_done) begin failures++; $display("FAIL rand_key_done got %b exp %b", key_done, exp_done); end
            checks++; if (fifo_count !== 5'(q.size())) begin failures++; $display("FAIL rand_fifo_count got %0d exp %0d", fifo_count, q.size()); end
            checks++; if (busy !== (m_phase != 0 || q.size() != 0)) begin failures++; $display("FAIL rand_busy got %b", busy); end
        end
        key_valid = 1'b0;
        checks++; if (sent != 20) begin failures++; $display("FAIL rand_sent got %0d exp 20", sent); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_fifo_full();
        test_no_key();
        test_back_to_back();
        test_random();
        test_scan_error();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_model.md
# keypad_matrix_model

Parametrised, scan-synchronous keypad matrix emulator for top-level verification and hardware-in-the-loop self-test. It accepts a queue of key codes and plays each one as a release period followed by a press period. It drives the active-low `row_in` lines by following the DUT's actual active-low `col_out` scan, rather than by free-running time slots. It sits between the stimulus source (bench sequencer or debug core) and the DUT keypad scanner.

## Interface
- `ROWS`, 4, matrix rows
- `COLS`, 4, matrix columns
- `KEY_W`, 5, key-code width; code = row*COLS + col; codes ≥ ROWS*COLS mean "no key" (idle gap)
- `DEPTH`, 16, key FIFO depth (power of two)
- `RELEASE_SCANS`, 4, scan boundaries counted before a press (≥1)
- `PRESS_SCANS`, 2, full scans a key is held (≥1)

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous active-low reset
- `key_valid` in 1: key-code push request
- `key_code` in KEY_W: code to push
- `key_ready` out 1: FIFO not full; push accepted when `key_valid & key_ready`
- `col_out` in COLS: DUT column drive, active-low one-hot; column c active when `col_out[c]==0`
- `row_in` out ROWS: to DUT, active-low; row r asserted by driving bit r to 0
- `busy` out 1: key in progress or FIFO non-empty
- `key_done` out 1: one-cycle pulse at end of each key's press period
- `fifo_count` out $clog2(DEPTH+1): queued entries
- `scan_error` out 1: sticky illegal-`col_out` flag

## Operation
- The FIFO is first-word-fall-through. `key_ready = (fifo_count != DEPTH)`. A pop and a push in the same cycle are both honoured.
- Scan boundary: column 0 becomes active. `bnd = ~col_out[0] & ~prev_col0_active`, with `prev_col0_active` registered each cycle.
- Legal `col_out`: all ones, or exactly one zero. Any other value sets `scan_error` (sticky until reset) and forces `row_in` to all ones on the next cycle.
- FSM states: IDLE, RELEASE, PRESS.
  - IDLE: `row_in` is all ones. If the FIFO is non-empty, pop into `key_reg`, clear `cnt`, and go to RELEASE.
  - RELEASE: `row_in` is all ones. `cnt` increments on each `bnd`. On the edge where the RELEASE_SCANS-th `bnd` is seen, go to PRESS with `cnt=0`.
  - PRESS: `cnt` increments on each `bnd`. On the edge where the PRESS_SCANS-th `bnd` is seen, pulse `key_done`, drive `row_in` all ones, and go to IDLE.
- Row drive in PRESS: `row_in` is registered. Each cycle: if `key_reg < ROWS*COLS`, `col_out` is legal, and column `key_reg % COLS` is active, then `row_in` becomes all ones with bit `key_reg / COLS` cleared. Otherwise `row_in` is all ones.
- No-key codes walk through the FSM normally. `row_in` never asserts, and `key_done` still pulses.
- `busy = (state != IDLE) | (fifo_count != 0)`.
- `col_out` is assumed to be in the `clk` domain. No synchroniser.

## Timing
- Reset values: `row_in` all ones, `key_ready`=1, `busy`=0, `key_done`=0, `fifo_count`=0, `scan_error`=0, state IDLE, FIFO flushed.
- Reset mid-operation takes effect immediately (async). The key in flight is discarded.
- `row_in` follows `col_out` with 1-cycle latency.
- Pop latency: the pop happens on the first IDLE cycle with the FIFO non-empty. Back-to-back keys therefore spend exactly 1 IDLE cycle between `key_done` and the next RELEASE.
- Press length: PRESS is entered on a boundary, so the key is held for exactly PRESS_SCANS complete scans. The first release window may be a partial scan, so release lasts at least RELEASE_SCANS−1 complete scans.
- With `col_out` static, no boundaries occur and the FSM stalls in RELEASE or PRESS indefinitely. This is legal.
- `fifo_count` updates the cycle after a push or pop.

## Test plan
Defaults throughout. The scanner steps every 4 clocks through 1110, 1101, 1011, 0111.

1. Push code 6. → After 4 boundaries, `row_in`=1101 for 4 cycles, starting 1 cycle after each `col_out`=1011, over 2 scans. Then one `key_done` pulse, and `row_in`=1111.
2. `col_out` static at 1111; push 18 codes back-to-back. → The first code is popped; `fifo_count` reaches 16; `key_ready`=0. The 18th code stays pending until a pop frees a slot.
3. Push code 16 (no key). → `row_in` stays 1111 throughout. `key_done` pulses after 6 boundaries.
4. Drive `col_out`=1100 during PRESS of code 0. → `scan_error`=1 and `row_in`=1111 the next cycle. `scan_error` stays set after `col_out` becomes legal again.
5. Assert `rst_n` low mid-PRESS with 3 codes queued. → `row_in`=1111 immediately, `fifo_count`=0, `busy`=0. Normal operation resumes after release.
6. Push codes 1 then 15. → Two `key_done` pulses separated by ≥6 scans. `row_in` shows 1110 on column 1 and then 0111 on column 3, in order.
